// File: rtl/branch_predict_unit.sv
// Branch resolution plus direct-mapped BTB/BHT predictor: IF-side lookup, EX-side resolve and training.
// Optional perf counters are built only when BP_PERF_CNT_EN is defined.
module branch_predict_unit #(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_IF,
  output logic             pred_taken_IF,
  output logic [WIDTH-1:0] pred_target_IF,
  input  logic             valid_EX,
  input  logic [6:0]       opcode_EX,
  input  logic [2:0]       funct3_EX,
  input  logic [WIDTH-1:0] pc_EX,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             BrUn,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             pred_taken_EX,
  input  logic [WIDTH-1:0] pred_target_EX,
  output logic             taken_EX,
  output logic             mispredict_EX,
  output logic [WIDTH-1:0] redirect_pc_EX,
  output logic [31:0]      br_count,
  output logic [31:0]      mp_count
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = IDX_BITS + 2;
  localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic                r_is_jal [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
  logic [WIDTH-1:0]    r_target [ENTRIES];

  logic [IDX_BITS-1:0] w_idx_if, w_idx_ex;
  logic [TAG_BITS-1:0] w_tag_if, w_tag_ex;
  logic                w_hit_if, w_hit_ex;
  logic                w_unused_pc;

  assign w_idx_if    = pc_IF[IDX_BITS+1:2];
  assign w_tag_if    = pc_IF[TAG_HI:TAG_LO];
  assign w_idx_ex    = pc_EX[IDX_BITS+1:2];
  assign w_tag_ex    = pc_EX[TAG_HI:TAG_LO];
  assign w_unused_pc = ^{pc_IF[WIDTH-1:TAG_HI+1], pc_IF[1:0]};

  assign w_hit_if       = r_valid[w_idx_if] && (r_tag[w_idx_if] == w_tag_if);
  assign w_hit_ex       = r_valid[w_idx_ex] && (r_tag[w_idx_ex] == w_tag_ex);
  assign pred_taken_IF  = w_hit_if && (r_is_jal[w_idx_if] || r_cnt[w_idx_if][CNT_BITS-1]);
  assign pred_target_IF = pred_taken_IF ? r_target[w_idx_if] : '0;

  logic w_is_br, w_is_jal, w_is_jalr, w_is_ctrl, w_eq, w_lt, w_br_cond, w_taken_raw;

  assign w_is_br   = (opcode_EX == OP_BRANCH);
  assign w_is_jal  = (opcode_EX == OP_JAL);
  assign w_is_jalr = (opcode_EX == OP_JALR);
  assign w_is_ctrl = w_is_br || w_is_jal || w_is_jalr;
  assign w_eq      = (rs1 == rs2);
  assign w_lt      = BrUn ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

  always_comb begin
    w_br_cond = 1'b0;
    case (funct3_EX)
      3'b000:         w_br_cond = w_eq;
      3'b001:         w_br_cond = !w_eq;
      3'b100, 3'b110: w_br_cond = w_lt;
      3'b101, 3'b111: w_br_cond = !w_lt;
      default:        w_br_cond = 1'b0;
    endcase
  end

  assign w_taken_raw    = w_is_br ? w_br_cond : (w_is_jal || w_is_jalr);
  assign taken_EX       = valid_EX && w_taken_raw;
  assign mispredict_EX  = valid_EX && ((taken_EX != pred_taken_EX) ||
                          (taken_EX && pred_taken_EX && (target_EX != pred_target_EX)));
  assign redirect_pc_EX = !valid_EX ? '0 : (taken_EX ? target_EX : pc_EX + WIDTH'(4));

  // Single write port: the new contents of the EX-indexed entry are formed here.
  logic                w_wr_en, w_wr_valid, w_wr_is_jal;
  logic [CNT_BITS-1:0] w_wr_cnt;
  logic [WIDTH-1:0]    w_wr_target;

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_valid  = r_valid[w_idx_ex];
    w_wr_is_jal = r_is_jal[w_idx_ex];
    w_wr_cnt    = r_cnt[w_idx_ex];
    w_wr_target = r_target[w_idx_ex];
    if (valid_EX) begin
      if (w_is_br) begin
        if (w_hit_ex) begin
          w_wr_en = 1'b1;
          if (w_br_cond) begin
            w_wr_target = target_EX;
            if (r_cnt[w_idx_ex] != CNT_MAX) w_wr_cnt = r_cnt[w_idx_ex] + 1'b1;
          end else if (r_cnt[w_idx_ex] != '0) begin
            w_wr_cnt = r_cnt[w_idx_ex] - 1'b1;
          end
        end else if (w_br_cond) begin
          w_wr_en     = 1'b1;
          w_wr_valid  = 1'b1;
          w_wr_is_jal = 1'b0;
          w_wr_cnt    = CNT_WT;
          w_wr_target = target_EX;
        end
      end else if (w_is_jal) begin
        w_wr_en     = 1'b1;
        w_wr_valid  = 1'b1;
        w_wr_is_jal = 1'b1;
        w_wr_target = target_EX;
      end else if (w_is_jalr && w_hit_ex) begin
        w_wr_en    = 1'b1;
        w_wr_valid = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid[gi]  <= 1'b0;
        r_tag[gi]    <= '0;
        r_is_jal[gi] <= 1'b0;
        r_cnt[gi]    <= CNT_WNT;
        r_target[gi] <= '0;
      end else if (w_wr_en && (w_idx_ex == IDX_BITS'(gi))) begin
        r_valid[gi]  <= w_wr_valid;
        r_tag[gi]    <= w_tag_ex;
        r_is_jal[gi] <= w_wr_is_jal;
        r_cnt[gi]    <= w_wr_cnt;
        r_target[gi] <= w_wr_target;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_br_count, r_mp_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else begin
      if (valid_EX && w_is_ctrl) r_br_count <= r_br_count + 32'd1;
      if (mispredict_EX)         r_mp_count <= r_mp_count + 32'd1;
    end
  end
  assign br_count = r_br_count;
  assign mp_count = r_mp_count;
`else
  logic w_unused_ctrl;
  assign w_unused_ctrl = w_is_ctrl;
  assign br_count = '0;
  assign mp_count = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;
  localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_ALU = 7'h33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_IF, pred_target_IF, pc_EX, rs1, rs2, target_EX, pred_target_EX;
  logic [31:0] redirect_pc_EX, br_count, mp_count;
  logic        pred_taken_IF, valid_EX, BrUn, pred_taken_EX, taken_EX, mispredict_EX;
  logic [6:0]  opcode_EX;
  logic [2:0]  funct3_EX;

  int checks = 0;
  int failures = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF), .pred_taken_IF(pred_taken_IF),
    .pred_target_IF(pred_target_IF), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
    .funct3_EX(funct3_EX), .pc_EX(pc_EX), .rs1(rs1), .rs2(rs2), .BrUn(BrUn),
    .target_EX(target_EX), .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
    .taken_EX(taken_EX), .mispredict_EX(mispredict_EX), .redirect_pc_EX(redirect_pc_EX),
    .br_count(br_count), .mp_count(mp_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [31:0] pc, input logic e_taken, input logic [31:0] e_tgt);
    pc_IF = pc;
    #1;
    check($sformatf("pred_taken@%0h", pc), {31'b0, pred_taken_IF}, {31'b0, e_taken});
    check($sformatf("pred_tgt@%0h", pc), pred_target_IF, e_tgt);
  endtask

  // Drives one EX instruction and checks its combinational outputs; caller ticks.
  task automatic ex_drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic brun,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                          input logic e_taken, input logic e_mp, input logic [31:0] e_redir);
    valid_EX = 1'b1; opcode_EX = op; funct3_EX = f3; pc_EX = pc; rs1 = a; rs2 = b;
    BrUn = brun; target_EX = tgt; pred_taken_EX = pt; pred_target_EX = ptgt;
    #1;
    check($sformatf("taken@%0h", pc), {31'b0, taken_EX}, {31'b0, e_taken});
    check($sformatf("mispredict@%0h", pc), {31'b0, mispredict_EX}, {31'b0, e_mp});
    check($sformatf("redirect@%0h", pc), redirect_pc_EX, e_redir);
    if (op == OP_BR || op == OP_JAL || op == OP_JALR) exp_br++;
    if (e_mp) exp_mp++;
  endtask

  task automatic ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                    input logic [31:0] a, input logic [31:0] b, input logic brun,
                    input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                    input logic e_taken, input logic e_mp, input logic [31:0] e_redir);
    ex_drive(op, f3, pc, a, b, brun, tgt, pt, ptgt, e_taken, e_mp, e_redir);
    tick();
    valid_EX = 1'b0;
    pred_taken_EX = 1'b0;
  endtask

  task automatic check_counters();
`ifdef BP_PERF_CNT_EN
    check("br_count", br_count, exp_br);
    check("mp_count", mp_count, exp_mp);
`else
    check("br_count", br_count, 32'd0);
    check("mp_count", mp_count, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; pc_IF = 32'h100; valid_EX = 1'b0; opcode_EX = OP_BR; funct3_EX = 3'b000;
    pc_EX = 32'h100; rs1 = 32'd5; rs2 = 32'd5; BrUn = 1'b0; target_EX = 32'h140;
    pred_taken_EX = 1'b0; pred_target_EX = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    check_counters();

    // Empty table never predicts; idle EX drives zeros.
    for (int i = 0; i < 64; i++) predict(32'h100 + 32'(i) * 4, 1'b0, 32'h0);
    check("idle_taken", {31'b0, taken_EX}, 32'd0);
    check("idle_redirect", redirect_pc_EX, 32'd0);

    // BEQ training and counter saturation at 0x100.
    pc_IF = 32'h100;
    ex(OP_BR, 3'b000, 32'h100, 5, 5, 0, 32'h140, 0, 0,        1, 1, 32'h140);
    predict(32'h100, 1'b1, 32'h140);
    ex_drive(OP_BR, 3'b000, 32'h100, 1, 2, 0, 32'h140, 1, 32'h140, 0, 1, 32'h104);
    check("no_bypass", {31'b0, pred_taken_IF}, 32'd1);
    tick(); valid_EX = 1'b0;
    predict(32'h100, 1'b0, 32'h0);
    ex(OP_BR, 3'b000, 32'h100, 1, 2, 0, 32'h140, 0, 0,        0, 0, 32'h104);
    ex(OP_BR, 3'b000, 32'h100, 1, 2, 0, 32'h140, 0, 0,        0, 0, 32'h104);
    ex(OP_BR, 3'b000, 32'h100, 5, 5, 0, 32'h140, 0, 0,        1, 1, 32'h140);
    predict(32'h100, 1'b0, 32'h0);
    ex(OP_BR, 3'b000, 32'h100, 5, 5, 0, 32'h140, 0, 0,        1, 1, 32'h140);
    predict(32'h100, 1'b1, 32'h140);
    ex(OP_BR, 3'b000, 32'h100, 5, 5, 0, 32'h140, 1, 32'h140, 1, 0, 32'h140);
    ex(OP_BR, 3'b000, 32'h100, 5, 5, 0, 32'h140, 1, 32'h140, 1, 0, 32'h140);
    ex(OP_BR, 3'b000, 32'h100, 1, 2, 0, 32'h140, 1, 32'h140, 0, 1, 32'h104);
    predict(32'h100, 1'b1, 32'h140);
    ex(OP_BR, 3'b000, 32'h100, 5, 5, 0, 32'h140, 1, 32'h180, 1, 1, 32'h140);

    // Signed vs unsigned compares and other funct3 codes.
    ex(OP_BR, 3'b100, 32'h3F0, 32'hFFFFFFFF, 1, 0, 32'h320, 0, 0, 1, 1, 32'h320);
    predict(32'h3F0, 1'b1, 32'h320);
    ex(OP_BR, 3'b110, 32'h3F4, 32'hFFFFFFFF, 1, 1, 32'h330, 0, 0, 0, 0, 32'h3F8);
    predict(32'h3F4, 1'b0, 32'h0);
    ex(OP_BR, 3'b111, 32'h3F8, 32'hFFFFFFFF, 1, 1, 32'h340, 0, 0, 1, 1, 32'h340);
    ex(OP_BR, 3'b010, 32'h3FC, 3, 3, 0, 32'h350, 0, 0,            0, 0, 32'h400);
    ex(OP_BR, 3'b001, 32'h508, 7, 7, 0, 32'h550, 0, 0,            0, 0, 32'h50C);
    predict(32'h508, 1'b0, 32'h0);

    // JAL allocation, JALR miss and JALR alias invalidation.
    ex(OP_JAL, 3'b000, 32'h200, 0, 0, 0, 32'h80, 0, 0,        1, 1, 32'h80);
    predict(32'h200, 1'b1, 32'h80);
    ex(OP_JALR, 3'b000, 32'h204, 0, 0, 0, 32'h400, 0, 0,      1, 1, 32'h400);
    predict(32'h204, 1'b0, 32'h0);
    predict(32'h200, 1'b1, 32'h80);
    ex(OP_JALR, 3'b000, 32'h200, 0, 0, 0, 32'h90, 1, 32'h80,  1, 1, 32'h90);
    predict(32'h200, 1'b0, 32'h0);

    // Aliased non-control instruction predicted taken; pc+4 wraps.
    ex(OP_ALU, 3'b000, 32'hFFFFFFFC, 0, 0, 0, 32'h0, 1, 32'h10, 0, 1, 32'h0);

    check_counters();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_br = 0;
    exp_mp = 0;
    check_counters();
    predict(32'h3F0, 1'b0, 32'h0);
    predict(32'h100, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
